// File: rtl/router_dest_reader.sv
// -----------------------------------------------------------------------------
// router_dest_reader
//
// Read-side agent for one router output channel FIFO. It issues read strobes
// whenever the FIFO is non-empty and the consumer is ready, tracks the reads
// still in flight, and rebuilds the returned byte stream into packets:
//   header (addr = d[1:0], len = d[7:2]), len payload bytes, then one parity
//   byte equal to the XOR of header and payload.
// Framed bytes, sop/eop markers, a per-packet done/error pulse and saturating
// packet/error counters are presented to the downstream consumer.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   vld_out     in   channel FIFO non-empty
//   data_out    in   channel FIFO read data, valid RD_LAT cycles after read_enb
//   sink_ready  in   consumer can accept bytes
//   flush       in   drop packet in progress and all in-flight bytes
//   read_enb    out  FIFO read strobe
//   byte_out    out  delivered byte
//   byte_valid  out  byte_out valid this cycle
//   sop / eop   out  byte_out is header / parity byte
//   pkt_addr    out  header[1:0] of current packet (held until next header)
//   pkt_len     out  header[7:2] of current packet (held until next header)
//   pkt_done    out  one-cycle pulse alongside the eop byte
//   parity_err  out  with pkt_done: computed parity differs from received
//   pkt_count   out  completed packets, saturating
//   err_count   out  parity errors, saturating
// -----------------------------------------------------------------------------
module router_dest_reader #(
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vld_out,
    input  logic [7:0]       data_out,
    input  logic             sink_ready,
    input  logic             flush,
    output logic             read_enb,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic             sop,
    output logic             eop,
    output logic [1:0]       pkt_addr,
    output logic [5:0]       pkt_len,
    output logic             pkt_done,
    output logic             parity_err,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_HDR     = 2'd0,
        S_PAYLOAD = 2'd1,
        S_PARITY  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [RD_LAT-1:0] r_pipe;
    logic [7:0]        r_acc;
    logic [5:0]        r_rem;
    logic              w_arrive;
    logic              w_is_hdr;
    logic              w_is_par;

    // Reads are withheld during flush and reset so nothing new enters the
    // pipe while it is being cleared.
    assign read_enb = vld_out & sink_ready & ~flush & ~reset;

    // In-flight tracker: stage gi is high for a read issued gi+1 cycles ago,
    // so the last stage marks the cycle the FIFO data is on data_out.
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
        if (gi == 0) begin : g_head
            always_ff @(posedge clock) begin
                if (reset || flush) r_pipe[gi] <= 1'b0;
                else                r_pipe[gi] <= read_enb;
            end
        end else begin : g_tail
            always_ff @(posedge clock) begin
                if (reset || flush) r_pipe[gi] <= 1'b0;
                else                r_pipe[gi] <= r_pipe[gi-1];
            end
        end
    end

    // A byte landing in the flush cycle came from an earlier read and is dropped.
    assign w_arrive = r_pipe[RD_LAT-1] & ~flush;
    assign w_is_hdr = w_arrive && (r_state == S_HDR);
    assign w_is_par = w_arrive && (r_state == S_PARITY);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_HDR;
        else       r_state <= w_state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_HDR;
        end else if (w_arrive) begin
            case (r_state)
                S_HDR:     w_state_next = (data_out[7:2] == 6'd0) ? S_PARITY : S_PAYLOAD;
                S_PAYLOAD: w_state_next = (r_rem == 6'd1) ? S_PARITY : S_PAYLOAD;
                S_PARITY:  w_state_next = S_HDR;
                default:   w_state_next = S_HDR;
            endcase
        end
    end

    // ---------------- Datapath and registered outputs ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_out   <= 8'd0;
            byte_valid <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            pkt_addr   <= 2'd0;
            pkt_len    <= 6'd0;
            pkt_count  <= '0;
            err_count  <= '0;
            r_acc      <= 8'd0;
            r_rem      <= 6'd0;
        end else begin
            byte_valid <= w_arrive;
            sop        <= w_is_hdr;
            eop        <= w_is_par;
            pkt_done   <= w_is_par;
            parity_err <= w_is_par && (r_acc != data_out);

            if (w_arrive) byte_out <= data_out;

            if (w_is_hdr) begin
                pkt_addr <= data_out[1:0];
                pkt_len  <= data_out[7:2];
                r_acc    <= data_out;
                r_rem    <= data_out[7:2];
            end

            if (w_arrive && (r_state == S_PAYLOAD)) begin
                r_acc <= r_acc ^ data_out;
                r_rem <= r_rem - 6'd1;
            end

            if (w_is_par) begin
                if (pkt_count != '1) pkt_count <= pkt_count + CNT_W'(1);
                if ((r_acc != data_out) && (err_count != '1))
                    err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_router_dest_reader.sv
// -----------------------------------------------------------------------------
// Testbench for router_dest_reader. A simple channel FIFO model feeds the DUT
// with RD_LAT read latency; a monitor records every delivered byte, and the
// directed/random steps compare that record against a packet-level model.
// -----------------------------------------------------------------------------
module tb_router_dest_reader;

    localparam int RD_LAT = 2;
    localparam int CNT_W  = 8;
    localparam int CMAX   = 255;

    logic             clock = 1'b0;
    logic             reset;
    logic             vld_out;
    logic [7:0]       data_out;
    logic             sink_ready;
    logic             flush;
    logic             read_enb;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             sop;
    logic             eop;
    logic [1:0]       pkt_addr;
    logic [5:0]       pkt_len;
    logic             pkt_done;
    logic             parity_err;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] err_count;

    router_dest_reader #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .sink_ready (sink_ready),
        .flush      (flush),
        .read_enb   (read_enb),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .sop        (sop),
        .eop        (eop),
        .pkt_addr   (pkt_addr),
        .pkt_len    (pkt_len),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- channel FIFO model ----------------
    logic [7:0] mem [0:2047];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] dl [RD_LAT];

    assign vld_out  = (rd_ptr != wr_ptr);
    assign data_out = dl[RD_LAT-1];

    always @(posedge clock) begin
        if (read_enb) begin
            dl[0]  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end else begin
            dl[0] <= 8'hA5;
        end
        for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
    end

    // ---------------- monitor ----------------
    typedef struct packed {
        logic [7:0] b;
        logic       s;
        logic       e;
        logic       d;
        logic       pe;
        logic [1:0] a;
        logic [5:0] l;
    } rec_t;

    rec_t obs_q[$];
    rec_t exp_q[$];
    int   cyc_q[$];
    int   cyc = 0;
    int   exp_pkt = 0;
    int   exp_err = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        n_tests++;
        assert (!(read_enb && !vld_out)) else begin
            n_fail++;
            $error("FAIL rd_no_data: read_enb=%0b vld_out=%0b required no read", read_enb, vld_out);
        end
        if (byte_valid === 1'b1) begin
            obs_q.push_back({byte_out, sop, eop, pkt_done, parity_err, pkt_addr, pkt_len});
            cyc_q.push_back(cyc);
        end else begin
            n_tests++;
            assert ({sop, eop, pkt_done, parity_err} === 4'b0000) else begin
                n_fail++;
                $error("FAIL qual: flags=%b without byte_valid, required 0000",
                       {sop, eop, pkt_done, parity_err});
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Packet model: header from addr/len, parity is XOR of header+payload,
    // optionally corrupted. Only the first 'keep' bytes are expected to be
    // delivered; the packet counts only if it is delivered completely.
    task automatic add_packet(input logic [1:0] addr, input logic [7:0] pl[$],
                              input bit bad, input int keep);
        logic [7:0] pk[$];
        logic [7:0] acc;
        logic [7:0] par;
        logic [5:0] len;
        int         n;
        len = 6'(pl.size());
        pk.push_back({len, addr});
        foreach (pl[i]) pk.push_back(pl[i]);
        acc = 8'd0;
        foreach (pk[i]) acc ^= pk[i];
        par = bad ? (acc ^ 8'h01) : acc;
        pk.push_back(par);
        n = pk.size();
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = pk[i];
            wr_ptr++;
            if (i < keep)
                exp_q.push_back({pk[i], i == 0, i == n - 1, i == n - 1,
                                 (i == n - 1) && (acc != par), addr, len});
        end
        if (keep >= n) begin
            exp_pkt++;
            if (acc != par) exp_err++;
        end
    endtask

    task automatic drain(input int budget, input bit rnd);
        int k;
        k = 0;
        while (obs_q.size() < exp_q.size() && k < budget) begin
            @(negedge clock);
            if (rnd) sink_ready = ($urandom_range(0, 3) != 0);
            k++;
        end
        n_tests++;
        assert (k < budget) else begin
            n_fail++;
            $error("FAIL timeout: got %0d bytes required %0d", obs_q.size(), exp_q.size());
        end
        sink_ready = 1'b1;
        repeat (RD_LAT + 4) @(negedge clock);
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_nbytes"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_rec%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
        cyc_q.delete();
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_pkt_count"}, 32'(pkt_count), sat(exp_pkt));
        chk({tag, "_err_count"}, 32'(err_count), sat(exp_err));
    endtask

    // ---------------- directed and random steps ----------------
    logic [7:0] pl[$];
    logic [7:0] empty_pl[$];

    initial begin
        reset      = 1'b1;
        sink_ready = 1'b0;
        flush      = 1'b0;

        // reset state, and no reads while reset is high even with data waiting
        mem[wr_ptr] = 8'h77;
        wr_ptr++;
        sink_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_read_enb", 32'(read_enb), 0);
        chk("rst_outputs", {byte_valid, sop, eop, pkt_done, parity_err}, 0);
        chk("rst_byte_out", 32'(byte_out), 0);
        chk("rst_addr_len", {pkt_addr, pkt_len}, 0);
        chk_counters("rst");
        sink_ready = 1'b0;
        wr_ptr = rd_ptr;
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 1: basic 5-byte packet, consecutive delivery
        pl = '{8'h11, 8'h22, 8'h33};
        add_packet(2'd1, pl, 1'b0, 1000);
        chk("p1_hdr_byte", 32'(exp_q[0].b), 32'h0D);
        sink_ready = 1'b1;
        drain(50, 1'b0);
        if (cyc_q.size() >= 5) chk("p1_consecutive", cyc_q[4] - cyc_q[0], 4);
        compare("p1");
        chk("p1_addr_len", {pkt_addr, pkt_len}, {2'd1, 6'd3});
        chk_counters("p1");

        // 2: zero-length packet
        add_packet(2'd2, empty_pl, 1'b0, 1000);
        drain(50, 1'b0);
        if (cyc_q.size() >= 2) chk("p2_sop_eop_adj", cyc_q[1] - cyc_q[0], 1);
        compare("p2");
        chk("p2_addr_len", {pkt_addr, pkt_len}, {2'd2, 6'd0});
        chk_counters("p2");

        // 3: bad parity
        pl = '{8'h11, 8'h22, 8'h33};
        add_packet(2'd1, pl, 1'b1, 1000);
        drain(50, 1'b0);
        compare("p3");
        chk_counters("p3");

        // 4: back-to-back packets
        sink_ready = 1'b0;
        pl = '{8'h11, 8'h22, 8'h33};
        add_packet(2'd1, pl, 1'b0, 1000);
        add_packet(2'd2, empty_pl, 1'b0, 1000);
        @(negedge clock);
        sink_ready = 1'b1;
        drain(50, 1'b0);
        if (cyc_q.size() >= 7) chk("p4_b2b_gap", cyc_q[5] - cyc_q[4], 1);
        compare("p4");
        chk_counters("p4");

        // 5: backpressure after two reads
        sink_ready = 1'b0;
        pl = '{8'h44, 8'h55, 8'h66};
        add_packet(2'd3, pl, 1'b0, 1000);
        @(negedge clock);
        sink_ready = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 sink_ready = 1'b0;
        repeat (8) @(negedge clock);
        chk("p5_held_bytes", obs_q.size(), 2);
        sink_ready = 1'b1;
        drain(50, 1'b0);
        compare("p5");
        chk_counters("p5");

        // 6: flush after header + 1 payload with two reads in flight
        sink_ready = 1'b0;
        pl = '{8'h11, 8'h22, 8'h33};
        add_packet(2'd1, pl, 1'b0, 2);
        @(negedge clock);
        sink_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1 flush = 1'b1;
        sink_ready = 1'b0;
        @(posedge clock);
        #1 flush = 1'b0;
        repeat (8) @(negedge clock);
        wr_ptr = rd_ptr;
        compare("p6_flush");
        chk("p6_addr_len_hold", {pkt_addr, pkt_len}, {2'd1, 6'd3});
        chk_counters("p6_flush");
        add_packet(2'd2, empty_pl, 1'b0, 1000);
        sink_ready = 1'b1;
        drain(50, 1'b0);
        compare("p6_after");
        chk("p6_after_addr_len", {pkt_addr, pkt_len}, {2'd2, 6'd0});
        chk_counters("p6_after");

        // 7: reset mid-packet
        sink_ready = 1'b0;
        pl = '{8'h11, 8'h22, 8'h33};
        add_packet(2'd1, pl, 1'b0, 2);
        @(negedge clock);
        sink_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        sink_ready = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        exp_pkt = 0;
        exp_err = 0;
        repeat (8) @(negedge clock);
        wr_ptr = rd_ptr;
        compare("p7_reset");
        chk("p7_addr_len_zero", {pkt_addr, pkt_len}, 0);
        chk_counters("p7_reset");
        add_packet(2'd2, empty_pl, 1'b0, 1000);
        sink_ready = 1'b1;
        drain(50, 1'b0);
        compare("p7_after");
        chk_counters("p7_after");

        // 8: random packets with random consumer readiness
        sink_ready = 1'b0;
        for (int p = 0; p < 25; p++) begin
            pl.delete();
            for (int i = 0; i < $urandom_range(0, 9); i++) pl.push_back(8'($urandom));
            add_packet(2'($urandom), pl, ($urandom_range(0, 3) == 0), 1000);
        end
        drain(3000, 1'b1);
        compare("p8_rand");
        chk_counters("p8_rand");

        // 9: counter saturation with bad zero-length packets
        for (int p = 0; p < 260; p++) add_packet(2'd0, empty_pl, 1'b1, 1000);
        sink_ready = 1'b1;
        drain(3000, 1'b0);
        compare("p9_sat");
        chk_counters("p9_sat");
        chk("p9_pkt_all_ones", 32'(pkt_count), CMAX);
        chk("p9_err_all_ones", 32'(err_count), CMAX);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
